// File: rtl/trm_ctrl_fsm.sv
// rtl/trm_ctrl_fsm.sv - TRM multi-cycle control sequencer
// Fetch/decode/execute/memory/writeback FSM driving PC, IR, ALU, RF and memory-port controls.
module trm_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [15:0]      instr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic             cond_true,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_byte,
  output logic             addr_sel,
  output logic             ld_signed,
  output logic             ir_load,
  output logic             addr_load,
  output logic             pc_en,
  output logic             pc_sel,
  output logic [2:0]       alu_cls,
  output logic [3:0]       alu_fn,
  output logic             alu_imm,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_SHF  = 3'b001;
  localparam logic [2:0] OP_LDST = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b100;
  localparam logic [2:0] OP_TST  = 3'b101;
  localparam logic [2:0] OP_SYS  = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_FWAIT  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_WB     = 4'd4,
    S_MEM    = 4'd5,
    S_MWAIT  = 4'd6,
    S_HALT   = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  state_t     state;
  logic [2:0] op_q;
  logic [3:0] fn_q;
  logic       i_q;
  logic [3:0] ra_q;

  logic [2:0] d_op;
  logic [3:0] d_fn;
  logic       legal;
  logic       is_hlt;
  logic       is_ldst;
  logic       is_branch;
  logic       is_store;
  logic       ra_nz;
  logic       unused_rb;

  assign d_op      = instr[15:13];
  assign d_fn      = instr[12:9];
  assign unused_rb = ^instr[3:0];
  assign is_hlt    = (d_op == OP_SYS) && (d_fn == 4'b1100);
  assign is_ldst   = (op_q == OP_LDST);
  assign is_branch = (op_q == OP_BR);
  assign is_store  = fn_q[2];
  assign ra_nz     = (ra_q != 4'd0);

  always_comb begin
    legal = 1'b0;
    case (d_op)
      OP_ALU:        legal = d_fn inside {4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
      OP_SHF:        legal = d_fn inside {4'b1000, 4'b1010, 4'b1011};
      OP_LDST:       legal = d_fn inside {4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0110};
      OP_BR, OP_TST: legal = d_fn inside {4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1001};
      OP_SYS:        legal = is_hlt;
      default:       legal = 1'b0;
    endcase
  end

  // Controls are state decodes; only the handshake-dependent ones look at inputs.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_byte  = 1'b0;
    addr_sel  = 1'b0;
    ld_signed = 1'b0;
    ir_load   = 1'b0;
    addr_load = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    alu_cls   = 3'b000;
    alu_fn    = 4'b0000;
    alu_imm   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    case (state)
      S_FETCH: mem_req = run;
      S_FWAIT: ir_load = mem_rvalid;
      S_EXEC: begin
        if (is_ldst) begin
          alu_fn    = 4'b0100;
          alu_imm   = i_q;
          addr_load = 1'b1;
        end else if (is_branch) begin
          pc_en  = 1'b1;
          pc_sel = cond_true;
        end else begin
          alu_cls = op_q;
          alu_fn  = fn_q;
          alu_imm = i_q;
        end
      end
      S_WB: begin
        alu_cls = op_q;
        alu_fn  = fn_q;
        alu_imm = i_q;
        rf_we   = ra_nz;
        pc_en   = 1'b1;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = is_store;
        mem_byte  = fn_q[1];
        ld_signed = (fn_q == 4'b0010);
        pc_en     = mem_gnt && is_store;
      end
      S_MWAIT: begin
        // Sign-extension select stays valid while the load data returns.
        ld_signed = (fn_q == 4'b0010);
        rf_we     = mem_rvalid && ra_nz;
        wb_sel    = mem_rvalid;
        pc_en     = mem_rvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      op_q    <= 3'b000;
      fn_q    <= 4'b0000;
      i_q     <= 1'b0;
      ra_q    <= 4'd0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      // Every retiring cycle is exactly a cycle that advances the PC.
      if (pc_en) retired <= retired + CNT_W'(1);
      case (state)
        S_FETCH:  if (run && mem_gnt) state <= S_FWAIT;
        S_FWAIT:  if (mem_rvalid) state <= S_DECODE;
        S_DECODE: begin
          op_q <= d_op;
          fn_q <= d_fn;
          i_q  <= instr[8];
          ra_q <= instr[7:4];
          if (!legal) begin
            state   <= S_TRAP;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else if (is_hlt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_ldst)        state <= S_MEM;
          else if (is_branch) state <= S_FETCH;
          else                state <= S_WB;
        end
        S_WB:    state <= S_FETCH;
        S_MEM:   if (mem_gnt) state <= is_store ? S_FETCH : S_MWAIT;
        S_MWAIT: if (mem_rvalid) state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_trm_ctrl_fsm.sv
// tb/tb_trm_ctrl_fsm.sv - directed bench for trm_ctrl_fsm
// Memory responder with programmable gnt/rvalid delays; retire scoreboard.
module tb_trm_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic        cond_true = 1'b0;
  logic        mem_req, mem_we, mem_byte, addr_sel, ld_signed, ir_load, addr_load;
  logic        pc_en, pc_sel, alu_imm, rf_we, wb_sel, halted, illegal;
  logic [2:0]  alu_cls;
  logic [3:0]  alu_fn;
  logic [31:0] retired;

  trm_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .cond_true(cond_true), .mem_req(mem_req), .mem_we(mem_we),
    .mem_byte(mem_byte), .addr_sel(addr_sel), .ld_signed(ld_signed), .ir_load(ir_load),
    .addr_load(addr_load), .pc_en(pc_en), .pc_sel(pc_sel), .alu_cls(alu_cls),
    .alu_fn(alu_fn), .alu_imm(alu_imm), .rf_we(rf_we), .wb_sel(wb_sel),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int gnt_dly = 0, rv_dly = 0, wait_cnt = 0, rv_cnt = 0;
  logic rv_pending = 1'b0;
  logic retire_seen = 1'b0, dgnt_seen = 1'b0, prev_wait = 1'b0;
  logic [2:0] prev_ctl = 3'b000, last_dctl = 3'b000;
  logic [6:0] last_alu = 7'h00;
  int ret_cyc = 0, start_cyc = 0, dlen = 0, last_dlen = 0, req_cycles = 0, stable_bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_ctl;
  logic [20:0] outs;

  assign outs = {mem_req, mem_we, mem_byte, addr_sel, ld_signed, ir_load, addr_load, pc_en,
                 pc_sel, alu_cls, alu_fn, alu_imm, rf_we, wb_sel, halted, illegal};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder drives handshakes at negedge, then the monitor samples settled outputs.
  always @(negedge clk) begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (rv_pending) begin
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        rv_pending = 1'b0;
      end else rv_cnt--;
    end
    if (!rst_n) wait_cnt = 0;
    else if (mem_req) begin
      if (wait_cnt >= gnt_dly) begin
        mem_gnt = 1'b1;
        wait_cnt = 0;
        if (!mem_we) begin
          rv_pending = 1'b1;
          rv_cnt = rv_dly;
        end
      end else wait_cnt++;
    end
    #2;
    if (prev_wait && mem_req && ({mem_we, mem_byte, addr_sel} != prev_ctl)) stable_bad++;
    prev_wait = rst_n && mem_req && !mem_gnt;
    prev_ctl = {mem_we, mem_byte, addr_sel};
    if (mem_req) req_cycles++;
    if (mem_req && addr_sel) begin
      dlen++;
      if (mem_gnt) begin
        last_dlen = dlen;
        last_dctl = {mem_we, mem_byte, ld_signed};
        dlen = 0;
        dgnt_seen = 1'b1;
      end
    end
    if (addr_load) last_alu = {alu_cls, alu_fn};
    if (pc_en) begin
      ret_cyc = cyc;
      retire_seen = 1'b1;
      chk("retire_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_ctl = exp_q.pop_front();
        chk("retire_ctl", {28'd0, rf_we, wb_sel, pc_sel, mem_we}, {28'd0, exp_ctl});
      end
    end
  end

  task automatic do_instr(input logic [15:0] w, input int gd, input int rd, input logic cond,
                          input logic [3:0] ectl, input int elat, input string tag);
    @(posedge clk); #1;
    instr = w;
    gnt_dly = gd;
    rv_dly = rd;
    cond_true = cond;
    retire_seen = 1'b0;
    dgnt_seen = 1'b0;
    exp_q.push_back(ectl);
    start_cyc = cyc;
    run = 1'b1;
    for (int k = 0; k < 80 && !retire_seen; k++) @(posedge clk);
    #1 run = 1'b0;
    chk({tag, "_done"}, 32'(retire_seen), 1);
    chk({tag, "_lat"}, ret_cyc - start_cyc + 1, elat);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    chk("reset_outs", 32'(outs), 0);
    chk("reset_retired", retired, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_instr(16'h0912, 0, 0, 1'b0, 4'b1000, 5, "add_imm");
    chk("add_retired", retired, 1);

    do_instr(16'h4034, 3, 2, 1'b0, 4'b1100, 16, "ldw_slow");
    chk("ldw_req_len", last_dlen, 4);
    chk("ldw_req_ctl", 32'(last_dctl), 0);
    chk("ldw_addr_alu", 32'(last_alu), 32'h04);
    chk("req_stable", stable_bad, 0);
    chk("ldw_retired", retired, 2);

    do_instr(16'h8025, 0, 0, 1'b1, 4'b0010, 4, "beq_taken");
    do_instr(16'h8025, 0, 0, 1'b0, 4'b0000, 4, "beq_not");
    chk("beq_retired", retired, 4);

    do_instr(16'h4801, 0, 0, 1'b0, 4'b0001, 5, "stw_r0");
    chk("stw_req_ctl", 32'(last_dctl), 32'h4);
    do_instr(16'h4456, 0, 0, 1'b0, 4'b1100, 6, "ldb");
    chk("ldb_req_ctl", 32'(last_dctl), 32'h3);
    do_instr(16'h3173, 0, 0, 1'b0, 4'b1000, 5, "shift_imm");
    chk("mix_retired", retired, 7);

    // Reset while a load waits in MWAIT; its late rvalid must be ignored.
    @(posedge clk); #1;
    instr = 16'h4034; gnt_dly = 0; rv_dly = 6; dgnt_seen = 1'b0; run = 1'b1;
    for (int k = 0; k < 40 && !dgnt_seen; k++) @(posedge clk);
    #1 run = 1'b0;
    chk("mid_load_granted", 32'(dgnt_seen), 1);
    @(negedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", 32'(outs), 0);
    chk("mid_reset_retired", retired, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("stale_rvalid_outs", 32'(outs), 0);
    chk("stale_rvalid_retired", retired, 0);

    @(posedge clk); #1 instr = 16'hF800; gnt_dly = 0; rv_dly = 0; run = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("hlt_halted", 32'(halted), 1);
    chk("hlt_illegal", 32'(illegal), 0);
    chk("hlt_no_req", 32'(mem_req), 0);
    rst_n = 1'b0; run = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("hlt_reset_halted", 32'(halted), 0);

    @(posedge clk); #1 instr = 16'hC000; run = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("trap_halted", 32'(halted), 1);
    chk("trap_illegal", 32'(illegal), 1);
    start_cyc = req_cycles;
    repeat (20) @(posedge clk);
    #1;
    chk("trap_no_req", req_cycles - start_cyc, 0);
    chk("trap_retired", retired, 0);
    run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
